// File: rtl/crossfade_mixer_pkg.sv
// crossfade_mixer_pkg: shared FSM states, gain/saturation helpers and fade-step default
package crossfade_mixer_pkg;
   typedef enum logic [2:0] {IDLE, IN_MUL, IN_DONE, MIX, OUT_MUL, OUT_DONE, REST} state_t;
   function automatic int unity_of(input int dw, input int gs);
      return 1 << (dw - 1 - gs);
   endfunction
   function automatic longint sat_max(input int dw);
      return (longint'(1) << (dw - 1)) - 1;
   endfunction
   function automatic longint sat_min(input int dw);
      return -(longint'(1) << (dw - 1));
   endfunction
   function automatic int fade_step_default(input int dw, input int gs);
      return unity_of(dw, gs) >> 7;
   endfunction
endpackage

// File: rtl/crossfade_mixer_mul.sv
// sat_gain_mul: one-stage registered signed multiply, rescale by the gain format and saturate
module sat_gain_mul import crossfade_mixer_pkg::*; #(
   parameter int data_width = 16,
   parameter int gain_shift = 4
)(
   input  logic                         clk,
   input  logic                         reset,
   input  logic signed [data_width-1:0] i_a,
   input  logic signed [data_width-1:0] i_g,
   output logic signed [data_width-1:0] o_p
);
   localparam int PW = 2 * data_width;
   localparam logic signed [PW-1:0] P_MAX = PW'(sat_max(data_width));
   localparam logic signed [PW-1:0] P_MIN = PW'(sat_min(data_width));
   localparam logic signed [data_width-1:0] S_MAX = data_width'(sat_max(data_width));
   localparam logic signed [data_width-1:0] S_MIN = data_width'(sat_min(data_width));
   logic signed [PW-1:0] w_prod, w_shift;
   assign w_prod  = PW'(i_a) * PW'(i_g);
   assign w_shift = w_prod >>> (data_width - 1 - gain_shift);
   // register the clamped product
   always_ff @(posedge clk or posedge reset) begin
      if (reset) o_p <= '0;
      else o_p <= (w_shift > P_MAX) ? S_MAX : (w_shift < P_MIN) ? S_MIN : w_shift[data_width-1:0];
   end
endmodule

// File: rtl/crossfade_mixer.sv
// crossfade_mixer: gain stage plus n-pipe crossfading mixer sharing one multiplier
// Optional peak meter on out_sample: define CROSSFADE_MIXER_PEAK_METER_EN
module crossfade_mixer import crossfade_mixer_pkg::*; #(
   parameter int data_width = 16,
   parameter int gain_shift = 4,
   parameter int n_pipes    = 4,
   parameter int fade_step  = fade_step_default(data_width, gain_shift)
)(
   input  logic                              clk,
   input  logic                              reset,
   input  logic signed [data_width-1:0]      in_sample,
   input  logic                              in_sample_valid,
   output logic signed [data_width-1:0]      in_sample_out,
   output logic                              in_sample_ready,
   input  logic [n_pipes*data_width-1:0]     out_samples_in,
   input  logic                              out_samples_valid,
   output logic signed [data_width-1:0]      out_sample,
   output logic                              out_sample_ready,
   input  logic signed [data_width-1:0]      data_in,
   input  logic                              set_input_gain,
   input  logic                              set_output_gain,
   input  logic                              select_pipeline,
   input  logic [$clog2(n_pipes)-1:0]        select_index,
   output logic                              pipelines_swapping,
   output logic [$clog2(n_pipes)-1:0]        active_pipeline,
   output logic [data_width-1:0]             peak_level,
   input  logic                              peak_clear
);
   localparam int DW = data_width;
   localparam int IW = $clog2(n_pipes);
   localparam int KW = $clog2(n_pipes + 1);
   localparam int AW = DW + IW;
   localparam logic signed [DW-1:0] UNITY = DW'(unity_of(DW, gain_shift));
   localparam logic signed [DW-1:0] STEP  = DW'(fade_step);
   localparam logic signed [DW-1:0] S_MAX = DW'(sat_max(DW));
   localparam logic signed [DW-1:0] S_MIN = DW'(sat_min(DW));
   localparam logic signed [AW-1:0] A_MAX = AW'(sat_max(DW));
   localparam logic signed [AW-1:0] A_MIN = AW'(sat_min(DW));
   state_t r_state, w_next;
   logic [KW-1:0] r_k;
   logic [IW-1:0] r_target, w_sel;
   logic signed [AW-1:0] r_acc;
   logic signed [DW-1:0] r_in_gain, r_out_gain, r_op, r_gl;
   logic signed [DW-1:0] r_pipe_gain [n_pipes];
   logic signed [DW-1:0] w_gain_nx [n_pipes];
   logic signed [DW-1:0] w_pipe_s [n_pipes];
   logic signed [DW-1:0] w_acc_sat, w_mul_a, w_mul_g, w_p;
   logic w_acc_in, w_acc_out, w_fade_done;
   assign w_acc_in  = (r_state == IDLE) && in_sample_valid;
   assign w_acc_out = (r_state == IDLE) && !in_sample_valid && out_samples_valid;
   // the last MIX cycle (k == n_pipes) only drains the multiplier, so its operand index is a don't-care
   assign w_sel     = (r_k < KW'(n_pipes)) ? r_k[IW-1:0] : '0;
   assign w_acc_sat = (r_acc > A_MAX) ? S_MAX : (r_acc < A_MIN) ? S_MIN : r_acc[DW-1:0];
   assign w_mul_a   = (r_state == MIX) ? w_pipe_s[w_sel] : (r_state == OUT_MUL) ? w_acc_sat : r_op;
   assign w_mul_g   = (r_state == MIX) ? r_pipe_gain[w_sel] : r_gl;
   sat_gain_mul #(.data_width(DW), .gain_shift(gain_shift)) u_mul (
      .clk(clk), .reset(reset), .i_a(w_mul_a), .i_g(w_mul_g), .o_p(w_p)
   );
   // unpack pipe samples and compute the next crossfade gains and completion flag
   always_comb begin
      w_fade_done = 1'b1;
      for (int j = 0; j < n_pipes; j++) begin
         w_pipe_s[j]  = out_samples_in[j*DW +: DW];
         w_gain_nx[j] = (IW'(j) == r_target)
                        ? ((r_pipe_gain[j] > UNITY - STEP) ? UNITY : r_pipe_gain[j] + STEP)
                        : ((r_pipe_gain[j] < STEP) ? '0 : r_pipe_gain[j] - STEP);
         w_fade_done  = w_fade_done && (w_gain_nx[j] == ((IW'(j) == r_target) ? UNITY : '0));
      end
   end
   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else r_state <= w_next;
   end
   // next-state logic; REST gives upstream a cycle to drop valid after its ready pulse
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:     w_next = w_acc_in ? IN_MUL : w_acc_out ? MIX : IDLE;
         IN_MUL:   w_next = IN_DONE;
         IN_DONE:  w_next = REST;
         MIX:      w_next = (r_k == KW'(n_pipes)) ? OUT_MUL : MIX;
         OUT_MUL:  w_next = OUT_DONE;
         OUT_DONE: w_next = REST;
         default:  w_next = IDLE;
      endcase
   end
   // operand latching, mix accumulation and registered results with ready pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_k              <= '0;
         r_acc            <= '0;
         r_op             <= '0;
         r_gl             <= '0;
         in_sample_out    <= '0;
         in_sample_ready  <= 1'b0;
         out_sample       <= '0;
         out_sample_ready <= 1'b0;
      end else begin
         r_k <= (r_state == MIX) ? r_k + 1'b1 : '0;
         if (r_state == MIX && r_k != '0) r_acc <= r_acc + AW'(w_p);
         else if (w_acc_out) r_acc <= '0;
         if (w_acc_in) begin
            r_op <= in_sample;
            r_gl <= r_in_gain;
         end else if (w_acc_out) r_gl <= r_out_gain;
         in_sample_ready  <= (r_state == IN_DONE);
         out_sample_ready <= (r_state == OUT_DONE);
         if (r_state == IN_DONE) in_sample_out <= w_p;
         if (r_state == OUT_DONE) out_sample <= w_p;
      end
   end
   // gain registers, crossfade stepping on each accepted input sample, pipeline selection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_in_gain          <= UNITY;
         r_out_gain         <= UNITY;
         r_target           <= '0;
         pipelines_swapping <= 1'b0;
         active_pipeline    <= '0;
         for (int j = 0; j < n_pipes; j++) r_pipe_gain[j] <= (j == 0) ? UNITY : '0;
      end else begin
         if (set_input_gain) r_in_gain <= data_in;
         if (set_output_gain) r_out_gain <= data_in;
         if (w_acc_in && pipelines_swapping) begin
            for (int j = 0; j < n_pipes; j++) r_pipe_gain[j] <= w_gain_nx[j];
            if (w_fade_done) begin
               pipelines_swapping <= 1'b0;
               active_pipeline    <= r_target;
            end
         end
         if (select_pipeline && {1'b0, select_index} < (IW+1)'(n_pipes) && select_index != r_target) begin
            r_target           <= select_index;
            pipelines_swapping <= 1'b1;
         end
      end
   end
`ifdef CROSSFADE_MIXER_PEAK_METER_EN
   logic [DW-1:0] w_mag;
   assign w_mag = (w_p == S_MIN) ? S_MAX : w_p[DW-1] ? -w_p : w_p;
   // track the largest output magnitude; a clear alongside a new sample restarts from that sample
   always_ff @(posedge clk or posedge reset) begin
      if (reset) peak_level <= '0;
      else if (r_state == OUT_DONE) peak_level <= (peak_clear || w_mag > peak_level) ? w_mag : peak_level;
      else if (peak_clear) peak_level <= '0;
   end
`else
   logic w_unused_peak;
   assign w_unused_peak = peak_clear;
   assign peak_level    = '0;
`endif
endmodule

// File: tb/tb_crossfade_mixer.sv
// tb_crossfade_mixer: directed checks of gain path, mixing, crossfade, priority, reset and peak meter
module tb_crossfade_mixer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic signed [15:0] in_sample, in_sample_out, out_sample, data_in;
   logic in_sample_valid, in_sample_ready, out_samples_valid, out_sample_ready;
   logic [63:0] out_samples_in;
   logic set_input_gain, set_output_gain, select_pipeline, pipelines_swapping, peak_clear;
   logic [1:0] select_index, active_pipeline;
   logic [15:0] peak_level;
   int errors = 0;
   int checks = 0;
   crossfade_mixer dut (
      .clk(clk), .reset(reset),
      .in_sample(in_sample), .in_sample_valid(in_sample_valid),
      .in_sample_out(in_sample_out), .in_sample_ready(in_sample_ready),
      .out_samples_in(out_samples_in), .out_samples_valid(out_samples_valid),
      .out_sample(out_sample), .out_sample_ready(out_sample_ready),
      .data_in(data_in), .set_input_gain(set_input_gain), .set_output_gain(set_output_gain),
      .select_pipeline(select_pipeline), .select_index(select_index),
      .pipelines_swapping(pipelines_swapping), .active_pipeline(active_pipeline),
      .peak_level(peak_level), .peak_clear(peak_clear)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic set_pipes(input int p0, input int p1, input int p2, input int p3);
      out_samples_in = {16'(p3), 16'(p2), 16'(p1), 16'(p0)};
   endtask
   task automatic write_gain(input bit is_out, input int v);
      @(negedge clk);
      data_in = 16'(v);
      if (is_out) set_output_gain = 1'b1;
      else set_input_gain = 1'b1;
      @(posedge clk);
      #1;
      set_input_gain  = 1'b0;
      set_output_gain = 1'b0;
   endtask
   task automatic select(input int idx);
      @(negedge clk);
      select_index    = 2'(idx);
      select_pipeline = 1'b1;
      @(posedge clk);
      #1;
      select_pipeline = 1'b0;
   endtask
   task automatic do_in(input int s, input int exp, input string tag);
      int n = 0;
      @(negedge clk);
      in_sample       = 16'(s);
      in_sample_valid = 1'b1;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!in_sample_ready && n < 40);
      in_sample_valid = 1'b0;
      check({tag, "_lat"}, n, 3);
      check(tag, in_sample_out, exp);
      @(posedge clk);
   endtask
   task automatic do_out(input int exp, input string tag);
      int n = 0;
      @(negedge clk);
      out_samples_valid = 1'b1;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!out_sample_ready && n < 40);
      out_samples_valid = 1'b0;
      check({tag, "_lat"}, n, 8);
      check(tag, out_sample, exp);
      @(posedge clk);
   endtask
   initial begin
      int n;
      bit seen;
      in_sample = '0; in_sample_valid = 0; out_samples_in = '0; out_samples_valid = 0;
      data_in = '0; set_input_gain = 0; set_output_gain = 0; select_pipeline = 0;
      select_index = '0; peak_clear = 0;
      #1;
      check("rst_in_out", in_sample_out, 0);
      check("rst_in_rdy", in_sample_ready, 0);
      check("rst_out", out_sample, 0);
      check("rst_out_rdy", out_sample_ready, 0);
      check("rst_swap", pipelines_swapping, 0);
      check("rst_active", active_pipeline, 0);
      check("rst_peak", peak_level, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      do_in(1000, 1000, "unity_in");
      write_gain(0, 4096);
      do_in(20000, 32767, "sat_pos");
      do_in(-20000, -32768, "sat_neg");
      write_gain(0, 2048);
      set_pipes(1000, 2000, 3000, 4000);
      do_out(1000, "mix_p0");
      select(2);
      check("swap_set", pipelines_swapping, 1);
      check("active_hold", active_pipeline, 0);
      for (int i = 0; i < 64; i++) do_in(100, 100, "fade_in");
      check("swap_mid", pipelines_swapping, 1);
      do_out(2000, "mix_half");
      for (int i = 0; i < 63; i++) do_in(-100, -100, "fade_in2");
      check("swap_127", pipelines_swapping, 1);
      check("active_127", active_pipeline, 0);
      do_in(7, 7, "fade_last");
      check("swap_done", pipelines_swapping, 0);
      check("active_done", active_pipeline, 2);
      do_out(3000, "mix_p2");
      @(negedge clk);
      in_sample = 16'sd500; in_sample_valid = 1'b1; out_samples_valid = 1'b1;
      n = 0; seen = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         seen |= out_sample_ready;
      end while (!in_sample_ready && n < 40);
      in_sample_valid = 1'b0;
      check("both_in_lat", n, 3);
      check("both_in_val", in_sample_out, 500);
      check("both_no_early_out", seen, 0);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!out_sample_ready && n < 40);
      out_samples_valid = 1'b0;
      check("both_out_lat", n, 9);
      check("both_out_val", out_sample, 3000);
      @(posedge clk);
      write_gain(1, 4096);
      do_out(6000, "out_gain");
      write_gain(0, 4096);
      @(negedge clk);
      out_samples_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      out_samples_valid = 1'b0;
      #1;
      check("mid_rst_rdy", out_sample_ready, 0);
      check("mid_rst_out", out_sample, 0);
      check("mid_rst_swap", pipelines_swapping, 0);
      check("mid_rst_active", active_pipeline, 0);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (15) begin
         @(posedge clk);
         #1;
         seen |= out_sample_ready;
      end
      check("no_stale_rdy", seen, 0);
      do_out(1000, "post_rst_mix");
      do_in(1000, 1000, "post_rst_in");
      set_pipes(-5000, 0, 0, 0);
      do_out(-5000, "neg_out");
      set_pipes(3000, 0, 0, 0);
      do_out(3000, "pos_out");
`ifdef CROSSFADE_MIXER_PEAK_METER_EN
      check("peak_max", peak_level, 5000);
`else
      check("peak_off", peak_level, 0);
`endif
      @(negedge clk);
      peak_clear = 1'b1;
      @(posedge clk);
      #1;
      peak_clear = 1'b0;
      check("peak_clr", peak_level, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/crossfade_mixer.md
CROSSFADE_MIXER -- requirements
Module: crossfade_mixer

Interface
REQ-001 SHALL have parameter data_width, default 16, sample and gain width.
REQ-002 SHALL have parameter gain_shift, default 4; gains are signed q(gain_shift+1).(data_width-1-gain_shift), so unity = 1<<(data_width-1-gain_shift).
REQ-003 SHALL have parameter n_pipes, default 4, range 2..8, the number of pipeline outputs mixed.
REQ-004 SHALL have parameter fade_step, default unity>>7, the crossfade gain increment per input sample.
REQ-005 SHALL have ports: clk in 1 clock; reset in 1 asynchronous active-high reset.
REQ-006 SHALL have ports: in_sample in data_width; in_sample_valid in 1; in_sample_out out data_width; in_sample_ready out 1 (pulse).
REQ-007 SHALL have ports: out_samples_in in n_pipes*data_width (pipe k at bits [k*data_width +: data_width]); out_samples_valid in 1; out_sample out data_width; out_sample_ready out 1 (pulse).
REQ-008 SHALL have ports: data_in in data_width; set_input_gain in 1; set_output_gain in 1; select_pipeline in 1 (strobe); select_index in clog2(n_pipes).
REQ-009 SHALL have ports: pipelines_swapping out 1; active_pipeline out clog2(n_pipes); peak_level out data_width; peak_clear in 1.

Function
REQ-010 SHALL use one shared signed multiplier: product >>> (data_width-1-gain_shift), saturated to [-2^(dw-1), 2^(dw-1)-1].
REQ-011 SHALL use FSM states IDLE, IN_MUL, IN_DONE, MIX (iterates k=0..n_pipes-1), OUT_MUL, OUT_DONE, REST; REST always returns to IDLE.
REQ-012 SHALL sample valids only in IDLE; upstream holds valid until the matching ready pulse.
REQ-013 SHALL give in_sample_valid priority over out_samples_valid when both are high in IDLE.
REQ-014 SHALL pulse in_sample_ready for one cycle, with in_sample_out = sat(in_sample*input_gain), exactly 3 cycles after acceptance.
REQ-015 SHALL, in MIX, add one saturated per-pipe product per cycle into an accumulator of data_width+clog2(n_pipes) bits, saturate the sum to data_width, then apply output_gain.
REQ-016 SHALL pulse out_sample_ready exactly n_pipes+4 cycles after acceptance.
REQ-017 SHALL load gain writes (set_input_gain/set_output_gain from data_in) in any state; new values take effect at the next acceptance.
REQ-018 SHALL, on select_pipeline with select_index < n_pipes and != target, latch target and set pipelines_swapping.
REQ-019 SHALL ignore select strobes where index >= n_pipes or index == current target.
REQ-020 SHALL, while swapping, on each accepted input sample add fade_step to target gain (clamped to unity) and subtract it from every other gain (clamped to 0).
REQ-021 SHALL clear pipelines_swapping and set active_pipeline = target on the step where target == unity and all others == 0.
REQ-022 SHALL retarget from current gains, without jumping, on a select during a swap (latest wins).

Reset
REQ-023 SHALL, on reset assertion, force immediately: all outputs 0 (active_pipeline 0), state IDLE, input_gain = output_gain = unity, pipe 0 gain unity, other gains 0, target 0.
REQ-024 SHALL abandon any in-flight operation on reset, with no ready pulse issued afterward for it.

Configuration
REQ-025 SHALL, when macro CROSSFADE_MIXER_PEAK_METER_EN is defined, hold in peak_level the max |out_sample| (|-32768| saturates to 32767) since reset or peak_clear; a clear coincident with a new sample loads that sample's magnitude.
REQ-026 SHALL, without the macro, tie peak_level to 0, ignore peak_clear, and synthesize no meter logic.

Structure
REQ-027 SHALL place the FSM state enum, the unity/saturation-limit functions and the fade-step default in package crossfade_mixer_pkg.
REQ-028 SHALL implement the multiply-shift-saturate as sub-module sat_gain_mul (one register stage), instantiated once.

Verification
REQ-029 SHALL check (dw=16, gs=4, unity 2048): in_sample=1000, default gain -> in_sample_out=1000, ready 3 cycles after valid.
REQ-030 SHALL check input_gain=4096, in_sample=20000 -> 32767; in_sample=-20000 -> -32768.
REQ-031 SHALL check n_pipes=4, pipes {1000,2000,3000,4000}, pipe 0 active -> out_sample=1000, ready 8 cycles after valid.
REQ-032 SHALL check select pipe 2 -> after 64 input samples gains 1024/1024 and mix 2000; after 128 swapping=0, active=2, mix 3000.
REQ-033 SHALL check both valids high in IDLE -> input path served first, mix ready afterward; reset mid-MIX -> no out_sample_ready, gains restored.
REQ-034 SHALL check with the meter enabled: outputs -5000, 3000 -> peak 5000; peak_clear -> 0.
